// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulation run controller.
//   state_e     : run sequencing states HOLD -> INIT -> RUN -> DRAIN -> DONE
//   CODE_GOOD   : exit code meaning "no error"
//   CODE_MAXCYC : default exit code reported when the cycle limit stops a run
package sim_ctrl_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [7:0] CODE_GOOD   = 8'h00;
    localparam logic [7:0] CODE_MAXCYC = 8'hFE;

endpackage : sim_ctrl_pkg

// File: rtl/sim_down_counter.sv
// Loadable down counter that stops at zero.
// Ports:
//   clock  in  1  clock
//   reset  in  1  asynchronous active-high reset, clears the count to 0
//   load   in  1  load value into the count (has priority over en)
//   value  in  W  value to load
//   en     in  1  decrement by one while the count is nonzero
//   zero   out 1  count is zero
module sim_down_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule : sim_down_counter

// File: rtl/sim_run_ctrl.sv
// Sequences one simulation run of SimTop: holds the core in reset, performs
// the one-shot DPI init handshake, enables per-cycle stepping while counting
// cycles and gating the log window, stops on a step error or the cycle limit,
// drains log/UART output, then raises a sticky finish with an exit code.
// Ports:
//   clock        in  1   simulation clock
//   reset        in  1   asynchronous active-high reset
//   max_cycles   in  64  RUN-cycle limit, 0 = unlimited, latched on INIT->RUN
//   log_begin    in  64  first cycle_count value with log_en high
//   log_end      in  64  last cycle_count value with log_en high, 0 disables
//   init_ack     in  1   DPI init complete
//   step_valid   in  1   step result present this cycle
//   step_code    in  8   step result, nonzero stops the run with this code
//   core_reset   out 1   reset to SimTop
//   init_req     out 1   init request level
//   step_en      out 1   call simv_step this cycle
//   cycle_count  out 64  RUN cycles elapsed
//   log_en       out 1   log window active
//   heartbeat    out 1   one-cycle pulse every HB_INTERVAL RUN cycles
//   finish       out 1   run complete (sticky until reset)
//   exit_code    out 8   valid while finish is high, 0 otherwise
//   dbg_state    out 3   current sequencing state (state_e encoding)
//
// Handshakes: init_req is a level request raised only in INIT and held until
// init_ack is seen high at a clock edge; init_ack may already be high in the
// first INIT cycle. step_valid/step_code form a valid-only channel with no
// back-pressure: a result is consumed in any RUN cycle where step_valid is
// high and ignored in every other state.
module sim_run_ctrl #(
    parameter int         RESET_HOLD   = 1000,
    parameter int         DRAIN_CYCLES = 16,
    parameter int         HB_INTERVAL  = 10000,
    parameter logic [7:0] CODE_MAXCYC  = sim_ctrl_pkg::CODE_MAXCYC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] max_cycles,
    input  logic [63:0] log_begin,
    input  logic [63:0] log_end,
    input  logic        init_ack,
    input  logic        step_valid,
    input  logic [7:0]  step_code,
    output logic        core_reset,
    output logic        init_req,
    output logic        step_en,
    output logic [63:0] cycle_count,
    output logic        log_en,
    output logic        heartbeat,
    output logic        finish,
    output logic [7:0]  exit_code,
    output logic [2:0]  dbg_state
);

    import sim_ctrl_pkg::*;

    localparam int CW = 32;

    // The hold counter comes out of reset at zero, so the first HOLD cycle
    // only arms and loads it; the remaining RESET_HOLD-1 cycles count down.
    // Loading RESET_HOLD-2 makes the HOLD->INIT edge the RESET_HOLD-th edge.
    localparam logic [CW-1:0] HOLD_LOAD  = (RESET_HOLD >= 2) ? CW'(RESET_HOLD - 2) : '0;
    localparam bit            HOLD_SHORT = (RESET_HOLD <= 1);
    // Loaded on the stop edge, so DRAIN lasts DRAIN_CYCLES cycles.
    localparam logic [CW-1:0] DRAIN_LOAD = (DRAIN_CYCLES >= 1) ? CW'(DRAIN_CYCLES - 1) : '0;
    localparam logic [CW-1:0] HB_LAST    = (HB_INTERVAL >= 1) ? CW'(HB_INTERVAL - 1) : '0;
    localparam bit            HB_ON      = (HB_INTERVAL != 0);

    state_e        state;
    state_e        state_next;
    logic          hold_armed;
    logic [63:0]   cycle_q;
    logic [63:0]   max_q;
    logic [7:0]    code_q;
    logic [CW-1:0] hb_cnt;

    logic hold_load;
    logic hold_en;
    logic hold_zero;
    logic hold_done;
    logic drain_load;
    logic drain_en;
    logic drain_zero;
    logic stop_err;
    logic stop_lim;
    logic stop;
    logic hb_hit;

    sim_down_counter #(.W(CW)) u_hold_cnt (
        .clock (clock),
        .reset (reset),
        .load  (hold_load),
        .value (HOLD_LOAD),
        .en    (hold_en),
        .zero  (hold_zero)
    );

    sim_down_counter #(.W(CW)) u_drain_cnt (
        .clock (clock),
        .reset (reset),
        .load  (drain_load),
        .value (DRAIN_LOAD),
        .en    (drain_en),
        .zero  (drain_zero)
    );

    assign stop_err  = step_valid && (step_code != CODE_GOOD);
    assign stop_lim  = (max_q != 64'd0) && ((cycle_q + 64'd1) == max_q);
    assign stop      = stop_err || stop_lim;
    assign hb_hit    = HB_ON && (hb_cnt == HB_LAST);
    assign hold_done = hold_armed ? hold_zero : HOLD_SHORT;

    always_comb begin
        state_next = state;
        hold_load  = 1'b0;
        hold_en    = 1'b0;
        drain_load = 1'b0;
        drain_en   = 1'b0;
        case (state)
            HOLD: begin
                hold_load = !hold_armed;
                hold_en   = hold_armed;
                if (hold_done) begin
                    state_next = INIT;
                end
            end
            INIT: begin
                if (init_ack) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    drain_load = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                drain_en = 1'b1;
                if (drain_zero) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = HOLD;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= HOLD;
            hold_armed <= 1'b0;
            cycle_q    <= 64'd0;
            max_q      <= 64'd0;
            code_q     <= CODE_GOOD;
            hb_cnt     <= '0;
        end else begin
            state <= state_next;
            if (state == HOLD) begin
                hold_armed <= 1'b1;
            end
            if ((state == INIT) && init_ack) begin
                max_q <= max_cycles;
            end
            if (state == RUN) begin
                cycle_q <= cycle_q + 64'd1;
                hb_cnt  <= hb_hit ? '0 : hb_cnt + 1'b1;
                // A step error outranks the limit when both hit in one cycle.
                if (stop) begin
                    code_q <= stop_err ? step_code : CODE_MAXCYC;
                end
            end
        end
    end

    assign core_reset  = (state == HOLD);
    assign init_req    = (state == INIT);
    assign step_en     = (state == RUN);
    assign finish      = (state == DONE);
    assign exit_code   = (state == DONE) ? code_q : CODE_GOOD;
    assign heartbeat   = (state == RUN) && hb_hit;
    assign cycle_count = cycle_q;
    assign log_en      = (log_end != 64'd0) && (log_begin <= cycle_q) && (cycle_q <= log_end);
    assign dbg_state   = state;

endmodule : sim_run_ctrl

// File: tb/tb_sim_run_ctrl.sv
module tb_sim_run_ctrl;

    localparam int RESET_HOLD   = 10;
    localparam int DRAIN_CYCLES = 16;
    localparam int HB_INTERVAL  = 4;
    localparam int W            = 78;

    localparam int P_HOLD  = 0;
    localparam int P_INIT  = 1;
    localparam int P_RUN   = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;

    // clock / reset
    logic clock;
    logic reset;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic [63:0] max_cycles;
    logic [63:0] log_begin;
    logic [63:0] log_end;
    logic        init_ack;
    logic        step_valid;
    logic [7:0]  step_code;
    logic        core_reset;
    logic        init_req;
    logic        step_en;
    logic [63:0] cycle_count;
    logic        log_en;
    logic        heartbeat;
    logic        finish;
    logic [7:0]  exit_code;
    logic [2:0]  dbg_state;

    sim_run_ctrl #(
        .RESET_HOLD   (RESET_HOLD),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .HB_INTERVAL  (HB_INTERVAL),
        .CODE_MAXCYC  (8'hFE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .max_cycles  (max_cycles),
        .log_begin   (log_begin),
        .log_end     (log_end),
        .init_ack    (init_ack),
        .step_valid  (step_valid),
        .step_code   (step_code),
        .core_reset  (core_reset),
        .init_req    (init_req),
        .step_en     (step_en),
        .cycle_count (cycle_count),
        .log_en      (log_en),
        .heartbeat   (heartbeat),
        .finish      (finish),
        .exit_code   (exit_code),
        .dbg_state   (dbg_state)
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    int           checks;
    int           failures;
    string        scen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s/%s actual=%0h required=%0h t=%0t", scen, name, act, req, $time);
        end
    endtask

    // reference model: run phase plus elapsed counts
    int          m_phase;
    int          m_hold;
    int          m_drain;
    logic [63:0] m_count;
    logic [63:0] m_max;
    logic [7:0]  m_code;

    task automatic model_reset();
        m_phase = P_HOLD;
        m_hold  = 0;
        m_drain = 0;
        m_count = 64'd0;
        m_max   = 64'd0;
        m_code  = 8'h00;
    endtask

    function automatic logic [W-1:0] model_expect();
        logic hb;
        logic le;
        hb = (m_phase == P_RUN) && (((m_count + 64'd1) % 64'(HB_INTERVAL)) == 64'd0);
        le = (log_end != 64'd0) && (log_begin <= m_count) && (m_count <= log_end);
        return {m_phase == P_HOLD, m_phase == P_INIT, m_phase == P_RUN, m_count,
                le, hb, m_phase == P_DONE, (m_phase == P_DONE) ? m_code : 8'h00};
    endfunction

    task automatic model_advance();
        logic e;
        logic l;
        case (m_phase)
            P_HOLD: begin
                m_hold++;
                if (m_hold >= RESET_HOLD) m_phase = P_INIT;
            end
            P_INIT: begin
                if (init_ack) begin
                    m_phase = P_RUN;
                    m_max   = max_cycles;
                end
            end
            P_RUN: begin
                e = step_valid && (step_code != 8'h00);
                l = (m_max != 64'd0) && (m_count + 64'd1 == m_max);
                m_count = m_count + 64'd1;
                if (e || l) begin
                    m_code  = e ? step_code : 8'hFE;
                    m_phase = P_DRAIN;
                    m_drain = DRAIN_CYCLES;
                end
            end
            P_DRAIN: begin
                m_drain--;
                if (m_drain == 0) m_phase = P_DONE;
            end
            default: ;
        endcase
    endtask

    // observed per-scenario counts
    int          obs_cr;
    int          obs_ireq;
    int          obs_step;
    int          obs_drain;
    int          obs_log;
    logic [63:0] hb_seen[$];
    logic [63:0] hb_exp[0:2];
    logic [W-1:0] mon_e;

    // monitor: one expected entry per cycle, compared mid-cycle
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("core_reset",  64'(core_reset),  64'(mon_e[77]));
            chk("init_req",    64'(init_req),    64'(mon_e[76]));
            chk("step_en",     64'(step_en),     64'(mon_e[75]));
            chk("cycle_count", cycle_count,      mon_e[74:11]);
            chk("log_en",      64'(log_en),      64'(mon_e[10]));
            chk("heartbeat",   64'(heartbeat),   64'(mon_e[9]));
            chk("finish",      64'(finish),      64'(mon_e[8]));
            chk("exit_code",   64'(exit_code),   64'(mon_e[7:0]));
            if (core_reset) obs_cr++;
            if (init_req) obs_ireq++;
            if (step_en) obs_step++;
            if (log_en) obs_log++;
            if (!core_reset && !init_req && !step_en && !finish) obs_drain++;
            if (heartbeat) hb_seen.push_back(cycle_count);
        end
    end

    // driver tasks
    task automatic tick();
        exp_q.push_back(model_expect());
        @(posedge clock);
        model_advance();
        #1;
    endtask

    // Asserts reset between edges and checks outputs before any clock edge.
    task automatic apply_reset();
        reset = 1'b1;
        #1;
        chk("rst_core_reset",  64'(core_reset),  64'd1);
        chk("rst_init_req",    64'(init_req),    64'd0);
        chk("rst_step_en",     64'(step_en),     64'd0);
        chk("rst_cycle_count", cycle_count,      64'd0);
        chk("rst_heartbeat",   64'(heartbeat),   64'd0);
        chk("rst_finish",      64'(finish),      64'd0);
        chk("rst_exit_code",   64'(exit_code),   64'd0);
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_scenario(input string nm, input logic [63:0] mx, input int err_at,
                                input logic [7:0] err_code, input logic [63:0] lb,
                                input logic [63:0] le, input int ack_mode,
                                input int abort_phase, input int abort_after,
                                input int exp_log, input bit hb_check);
        logic [7:0]  ec;
        logic [63:0] cc;
        int          prev;
        int          in_phase;
        logic        done_seen;
        scen = nm;
        apply_reset();
        max_cycles = mx;
        log_begin  = lb;
        log_end    = le;
        obs_cr = 0; obs_ireq = 0; obs_step = 0; obs_drain = 0; obs_log = 0;
        hb_seen.delete();
        prev = -1;
        in_phase = 0;
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            init_ack   = (ack_mode == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
            step_valid = 1'($urandom_range(0, 1));
            step_code  = 8'h00;
            if (m_phase == P_RUN) begin
                if (err_at >= 0 && m_count == 64'(err_at)) begin
                    step_valid = 1'b1;
                    step_code  = err_code;
                end else if (!step_valid) begin
                    step_code = 8'($urandom_range(0, 255));
                end
            end else if (step_valid) begin
                step_code = 8'($urandom_range(1, 255));
            end
            if (m_phase == prev) in_phase++;
            else in_phase = 0;
            prev = m_phase;
            if (abort_phase >= 0 && m_phase == abort_phase && in_phase == abort_after) begin
                scen = {nm, "_abort"};
                apply_reset();
                return;
            end
            if (m_phase == P_DONE && in_phase >= 3) begin
                done_seen = 1'b1;
                break;
            end
            tick();
        end
        if (err_at >= 0 && (mx == 64'd0 || 64'(err_at) < mx)) begin
            ec = err_code;
            cc = 64'(err_at) + 64'd1;
        end else begin
            ec = 8'hFE;
            cc = mx;
        end
        chk("reached_done",      64'(done_seen),   64'd1);
        chk("final_finish",      64'(finish),      64'd1);
        chk("final_exit_code",   64'(exit_code),   64'(ec));
        chk("final_cycle_count", cycle_count,      cc);
        chk("step_en_cycles",    64'(obs_step),    cc);
        chk("core_reset_cycles", 64'(obs_cr),      64'(RESET_HOLD));
        chk("drain_cycles",      64'(obs_drain),   64'(DRAIN_CYCLES));
        if (ack_mode == 0) chk("init_req_cycles", 64'(obs_ireq), 64'd1);
        if (exp_log >= 0) chk("log_en_cycles", 64'(obs_log), 64'(exp_log));
        if (hb_check) begin
            chk("hb_pulses", 64'(hb_seen.size()), 64'd3);
            for (int i = 0; i < 3 && i < hb_seen.size(); i++) begin
                chk("hb_cycle", hb_seen[i], hb_exp[i]);
            end
        end
    endtask

    initial begin
        int          err;
        logic [63:0] mx;
        checks     = 0;
        failures   = 0;
        scen       = "init";
        reset      = 1'b1;
        max_cycles = 64'd0;
        log_begin  = 64'd0;
        log_end    = 64'd0;
        init_ack   = 1'b0;
        step_valid = 1'b0;
        step_code  = 8'h00;
        hb_exp[0]  = 64'd3;
        hb_exp[1]  = 64'd7;
        hb_exp[2]  = 64'd11;
        model_reset();

        // limit stop, init timing, log window 5..8
        run_scenario("limit100", 64'd100, -1, 8'h00, 64'd5, 64'd8, 0, -1, 0, 4, 1'b0);
        // step error at cycle 42, unlimited, log disabled by log_end=0
        run_scenario("err42", 64'd0, 42, 8'h03, 64'd0, 64'd0, 0, -1, 0, 0, 1'b0);
        // error and limit on the same cycle, begin>end window
        run_scenario("both50", 64'd50, 49, 8'h01, 64'd9, 64'd3, 0, -1, 0, 0, 1'b0);
        // heartbeat positions
        run_scenario("hb12", 64'd12, -1, 8'h00, 64'd0, 64'd0, 0, -1, 0, -1, 1'b1);
        // reset mid-RUN, mid-DRAIN, then a complete run
        run_scenario("abort_run", 64'd60, -1, 8'h00, 64'd0, 64'd0, 1, P_RUN, 20, -1, 1'b0);
        run_scenario("abort_drain", 64'd30, -1, 8'h00, 64'd0, 64'd0, 1, P_DRAIN, 5, -1, 1'b0);
        run_scenario("after_abort", 64'd25, 7, 8'h5A, 64'd2, 64'd6, 1, -1, 0, 5, 1'b0);
        // randomized runs
        for (int r = 0; r < 8; r++) begin
            mx  = 64'($urandom_range(1, 80));
            err = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 90)) : -1;
            run_scenario($sformatf("rand%0d", r), mx, err, 8'($urandom_range(1, 255)),
                         64'($urandom_range(0, 60)), 64'($urandom_range(0, 60)),
                         int'($urandom_range(0, 1)), -1, 0, -1, 1'b0);
        end

        @(posedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sim_run_ctrl
